// File: rtl/eth_pkg.sv
// Shared types for the receive frame FIFO: one stored byte plus its frame flags,
// and the write-side FSM states.
package eth_pkg;

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 2;

  typedef struct packed {
    logic              user;
    logic              last;
    logic [DATA_W-1:0] data;
  } eth_fifo_entry_t;

  typedef enum logic {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_e;

endpackage

// File: rtl/eth_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
// The array has no reset; only the read register is enabled by rd_en.
module eth_fifo_ram
  import eth_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  eth_fifo_entry_t   wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output eth_fifo_entry_t   rd_data
);

  eth_fifo_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO behind the MAC: frames are committed on their last
// byte or discarded (bad FCS / no room); committed frames drain on a backpressured stream.
module eth_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH          = 4096,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit DROP_BAD_FRAME = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              status_good_frame,
  output logic              status_bad_frame,
  output logic              status_overflow,
  output logic [ADDR_W:0]   occupancy
);

  localparam int PTR_W = ADDR_W + 1;

  wr_state_e       wr_state, wr_state_n;
  logic [PTR_W-1:0] wr_ptr_cur, wr_ptr_cur_n;
  logic [PTR_W-1:0] wr_ptr_commit, wr_ptr_commit_n;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fill;
  logic             full, empty, load;
  logic             wr_en, good_pulse, bad_pulse, ovf_pulse;
  eth_fifo_entry_t  wr_entry, rd_entry;

  // fill counts uncommitted bytes too, so a frame in progress can hit full
  assign fill      = wr_ptr_cur - rd_ptr;
  assign full      = (fill == PTR_W'(DEPTH));
  assign empty     = (rd_ptr == wr_ptr_commit);
  assign occupancy = wr_ptr_commit - rd_ptr;

  assign wr_entry = '{user: s_axis_tuser & s_axis_tlast,
                      last: s_axis_tlast,
                      data: s_axis_tdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state          <= WR_ACCEPT;
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      wr_state          <= wr_state_n;
      wr_ptr_cur        <= wr_ptr_cur_n;
      wr_ptr_commit     <= wr_ptr_commit_n;
      status_good_frame <= good_pulse;
      status_bad_frame  <= bad_pulse;
      status_overflow   <= ovf_pulse;
    end
  end

  always_comb begin
    wr_state_n      = wr_state;
    wr_ptr_cur_n    = wr_ptr_cur;
    wr_ptr_commit_n = wr_ptr_commit;
    wr_en           = 1'b0;
    good_pulse      = 1'b0;
    bad_pulse       = 1'b0;
    ovf_pulse       = 1'b0;
    if (s_axis_tvalid) begin
      unique case (wr_state)
        WR_ACCEPT: begin
          if (!full) begin
            wr_en        = 1'b1;
            wr_ptr_cur_n = wr_ptr_cur + 1'b1;
            if (s_axis_tlast) begin
              if (s_axis_tuser && DROP_BAD_FRAME) begin
                wr_ptr_cur_n = wr_ptr_commit;
                bad_pulse    = 1'b1;
              end else begin
                wr_ptr_commit_n = wr_ptr_cur + 1'b1;
                good_pulse      = 1'b1;
              end
            end
          end else begin
            // Out of room: rewind to the last commit and discard the rest of the frame
            wr_ptr_cur_n = wr_ptr_commit;
            if (s_axis_tlast) ovf_pulse = 1'b1;
            else              wr_state_n = WR_DROP;
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            ovf_pulse  = 1'b1;
            wr_state_n = WR_ACCEPT;
          end
        end
        default: wr_state_n = WR_ACCEPT;
      endcase
    end
  end

  // The RAM read register doubles as the output register; tvalid tracks its contents.
  assign load = (!m_axis_tvalid || m_axis_tready) && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      rd_ptr        <= rd_ptr + 1'b1;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  eth_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_cur[ADDR_W-1:0]),
    .wr_data (wr_entry),
    .rd_en   (load),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_entry)
  );

  // Mask the unreset RAM register so idle outputs read as zero
  assign m_axis_tdata = m_axis_tvalid ? rd_entry.data : 8'h00;
  assign m_axis_tlast = m_axis_tvalid & rd_entry.last;
  assign m_axis_tuser = m_axis_tvalid & rd_entry.last & rd_entry.user;

endmodule
